// File: rtl/draw_cat.sv
// Cat sprite stage: computes the image ROM address and pose, then keys the ROM pixel
// over the background. Video passes through a two-register pipeline.
module draw_cat #(
  parameter logic [10:0] XPOS            = 11'd100,
  parameter logic [10:0] YPOS            = 11'd400,
  parameter int          IMG_W           = 130,
  parameter int          IMG_H           = 99,
  parameter int          FRAMES_PER_STEP = 8,
  parameter logic [11:0] TRANSPARENT     = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        throw,
  input  logic [11:0] rgb_pixel,
  output logic [13:0] pixel_addr,
  output logic [1:0]  state,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    THROW1 = 2'b01,
    THROW2 = 2'b10,
    BAD    = 2'b11
  } state_t;

  localparam int          CNT_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [10:0] X_LAST   = 11'(int'(XPOS) + IMG_W - 1);
  localparam logic [10:0] Y_LAST   = 11'(int'(YPOS) + IMG_H - 1);

  function automatic logic [11:0] key_merge(input logic inbox, input logic [11:0] fg,
                                            input logic [11:0] bg);
    return (inbox && (fg != TRANSPARENT)) ? fg : bg;
  endfunction

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             pend_q, pend_nxt;
  logic             vblnk_prev;
  logic             tick;

  logic        inbox;
  logic [10:0] dx, dy;
  logic [21:0] addr_full;

  logic [10:0] hcount_p1, vcount_p1;
  logic        hsync_p1, vsync_p1, hblnk_p1, vblnk_p1;
  logic [11:0] rgb_p1, rgb_p2;
  logic        inbox_p1, inbox_p2;

  assign tick  = vblnk_in & ~vblnk_prev;
  assign inbox = (hcount_in >= XPOS) && (hcount_in <= X_LAST) &&
                 (vcount_in >= YPOS) && (vcount_in <= Y_LAST);
  assign dx        = hcount_in - XPOS;
  assign dy        = vcount_in - YPOS;
  assign addr_full = 22'(dy) * 22'(IMG_W) + 22'(dx);

  always_ff @(posedge clk) begin
    if (rst) vblnk_prev <= 1'b0;
    else     vblnk_prev <= vblnk_in;
  end

  // Stage 1: ROM address and in-box flag alongside delayed video
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_addr <= '0;
      inbox_p1   <= 1'b0;
      hcount_p1  <= '0;
      vcount_p1  <= '0;
      hsync_p1   <= 1'b0;
      vsync_p1   <= 1'b0;
      hblnk_p1   <= 1'b0;
      vblnk_p1   <= 1'b0;
      rgb_p1     <= '0;
    end else begin
      pixel_addr <= inbox ? addr_full[13:0] : 14'd0;
      inbox_p1   <= inbox;
      hcount_p1  <= hcount_in;
      vcount_p1  <= vcount_in;
      hsync_p1   <= hsync_in;
      vsync_p1   <= vsync_in;
      hblnk_p1   <= hblnk_in;
      vblnk_p1   <= vblnk_in;
      rgb_p1     <= rgb_in;
    end
  end

  // Stage 2: aligned with the ROM data; compositing is a mux on the registered flag
  always_ff @(posedge clk) begin
    if (rst) begin
      inbox_p2   <= 1'b0;
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_p2     <= '0;
    end else begin
      inbox_p2   <= inbox_p1;
      hcount_out <= hcount_p1;
      vcount_out <= vcount_p1;
      hsync_out  <= hsync_p1;
      vsync_out  <= vsync_p1;
      hblnk_out  <= hblnk_p1;
      vblnk_out  <= vblnk_p1;
      rgb_p2     <= rgb_p1;
    end
  end

  assign rgb_out = key_merge(inbox_p2, rgb_pixel, rgb_p2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      pend_q  <= pend_nxt;
    end
  end

  // Pose changes only on the vblank rising edge so a frame never mixes poses
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    pend_nxt  = pend_q;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          if (tick) begin
            state_nxt = THROW1;
            pend_nxt  = 1'b0;
            cnt_nxt   = '0;
          end
        end else if (throw) begin
          pend_nxt = 1'b1;
        end
      end
      THROW1, THROW2: begin
        if (tick) begin
          if (cnt_q == CNT_LAST) begin
            state_nxt = (state_q == THROW1) ? THROW2 : IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        pend_nxt  = 1'b0;
      end
    endcase
  end

  assign state = state_q;
  assign busy  = (state_q != IDLE) || pend_q;

endmodule

// File: tb/tb_draw_cat.sv
// Bench for draw_cat: vector table, randomized pixels against a coordinate model,
// and hand sequences for the throw animation and reset.
module tb_draw_cat;

  localparam int XP  = 100;
  localparam int YP  = 400;
  localparam int W   = 130;
  localparam int H   = 99;
  localparam int FPS = 2;

  logic        clk, rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic        throw;
  logic [11:0] rgb_pixel;
  logic [13:0] pixel_addr;
  logic [1:0]  state;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        busy;

  logic        ovr_en;
  logic [11:0] ovr_val;
  int checks = 0;
  int failures = 0;

  draw_cat #(
    .XPOS(11'(XP)), .YPOS(11'(YP)), .IMG_W(W), .IMG_H(H),
    .FRAMES_PER_STEP(FPS), .TRANSPARENT(12'hF0F)
  ) dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .throw(throw), .rgb_pixel(rgb_pixel),
    .pixel_addr(pixel_addr), .state(state),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] rom_word(input int a);
    if (a % 7 == 3) return 12'hF0F;
    return 12'((a * 37) ^ 32'h6C3);
  endfunction

  // Image ROM with one cycle of read latency; override lets vectors pick the pixel
  always @(posedge clk) rgb_pixel <= ovr_en ? ovr_val : rom_word(int'(pixel_addr));

  function automatic bit in_box(input int h, input int v);
    return h >= XP && h < XP + W && v >= YP && v < YP + H;
  endfunction

  function automatic int model_addr(input int h, input int v);
    return in_box(h, v) ? ((v - YP) * W + (h - XP)) % 16384 : 0;
  endfunction

  function automatic logic [11:0] model_rgb(input int h, input int v, input logic [11:0] bg);
    logic [11:0] fg;
    if (!in_box(h, v)) return bg;
    fg = rom_word(model_addr(h, v));
    return (fg == 12'hF0F) ? bg : fg;
  endfunction

  // Pose after k ticks counted from the tick that starts the throw
  function automatic logic [1:0] model_state(input int k);
    if (k < 0) return 2'b00;
    if (k < FPS) return 2'b01;
    if (k < 2 * FPS) return 2'b10;
    return 2'b00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_px(input int h, input int v, input logic [11:0] c);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    rgb_in    = c;
  endtask

  task automatic do_tick();
    @(negedge clk) vblnk_in = 1'b1;
    @(negedge clk) vblnk_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_throw();
    @(negedge clk) throw = 1'b1;
    @(negedge clk) throw = 1'b0;
  endtask

  // Full throw from a fresh request; optionally re-requests after tick extra_at
  task automatic run_throw(input string tag, input int extra_at);
    pulse_throw();
    check({tag, "_pend_state"}, 32'(state), 32'(2'b00));
    check({tag, "_pend_busy"}, 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    check({tag, "_wait_state"}, 32'(state), 32'(2'b00));
    for (int k = 0; k <= 2 * FPS; k++) begin
      do_tick();
      check({tag, "_state"}, 32'(state), 32'(model_state(k)));
      check({tag, "_busy"}, 32'(busy), 32'(k < 2 * FPS));
      if (k == extra_at) pulse_throw();
    end
    do_tick();
    check({tag, "_after_state"}, 32'(state), 32'(2'b00));
  endtask

  typedef struct {
    int          h, v;
    logic [11:0] bg;
    logic        oen;
    logic [11:0] oval;
    int          exp_addr;
    logic [11:0] exp_rgb;
  } vec_t;

  typedef struct {
    int          h, v;
    logic        hs, vs, hb, vb;
    logic [11:0] bg;
  } pix_t;

  vec_t vecs[9];
  pix_t hist[300];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; throw = 1'b0; ovr_en = 1'b0; ovr_val = '0;
    hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b1; vblnk_in = 1'b0;
    drive_px(XP + 5, YP + 5, 12'hFFF);
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_addr", 32'(pixel_addr), 0);
    check("rst_timing", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, 0);
    check("rst_rgb", 32'(rgb_out), 0);

    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0;
    drive_px(0, 0, 12'h000);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Exact two-cycle alignment
    hsync_in = 1'b1;
    drive_px(5, 7, 12'h123);
    @(negedge clk);
    check("align_early", {hcount_out, vcount_out, hsync_out, 8'(rgb_out)}, 0);
    @(negedge clk);
    check("align_hv", {hcount_out, vcount_out}, {11'd5, 11'd7});
    check("align_sync", 32'(hsync_out), 1);
    check("align_rgb", 32'(rgb_out), 32'h123);
    hsync_in = 1'b0;

    vecs[0] = '{5, 7, 12'h123, 1'b0, 12'h000, 0, 12'h123};
    vecs[1] = '{XP + 3, YP + 2, 12'h456, 1'b0, 12'h000, 263, rom_word(263)};
    vecs[2] = '{XP + 129, YP + 98, 12'h321, 1'b0, 12'h000, 12869, 12'h321};
    vecs[3] = '{XP - 1, YP, 12'h777, 1'b0, 12'h000, 0, 12'h777};
    vecs[4] = '{XP + 10, YP + 10, 12'hABC, 1'b1, 12'hF0F, 1310, 12'hABC};
    vecs[5] = '{XP + 10, YP + 10, 12'hABC, 1'b1, 12'h0A0, 1310, 12'h0A0};
    vecs[6] = '{XP + W, YP + 50, 12'h246, 1'b1, 12'h0A0, 0, 12'h246};
    vecs[7] = '{XP + 50, YP + H, 12'h135, 1'b1, 12'h0A0, 0, 12'h135};
    vecs[8] = '{XP, YP, 12'h111, 1'b1, 12'h0A0, 0, 12'h0A0};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive_px(vecs[i].h, vecs[i].v, vecs[i].bg);
      ovr_en = vecs[i].oen;
      ovr_val = vecs[i].oval;
      @(negedge clk);
      check($sformatf("vec%0d_addr", i), 32'(pixel_addr), 32'(vecs[i].exp_addr));
      @(negedge clk);
      check($sformatf("vec%0d_rgb", i), 32'(rgb_out), 32'(vecs[i].exp_rgb));
    end
    ovr_en = 1'b0;

    // Randomized pixels near the sprite box
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i >= 1)
        check("rnd_addr", 32'(pixel_addr), 32'(model_addr(hist[i-1].h, hist[i-1].v)));
      if (i >= 2) begin
        check("rnd_timing",
              {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out},
              {11'(hist[i-2].h), 11'(hist[i-2].v), hist[i-2].hs, hist[i-2].vs,
               hist[i-2].hb, hist[i-2].vb});
        check("rnd_rgb", 32'(rgb_out), 32'(model_rgb(hist[i-2].h, hist[i-2].v, hist[i-2].bg)));
      end
      hist[i].h  = XP - 5 + int'($urandom_range(0, W + 9));
      hist[i].v  = YP - 5 + int'($urandom_range(0, H + 9));
      hist[i].hs = 1'($urandom);
      hist[i].vs = 1'($urandom);
      hist[i].hb = 1'($urandom);
      hist[i].vb = 1'($urandom);
      hist[i].bg = 12'($urandom);
      drive_px(hist[i].h, hist[i].v, hist[i].bg);
      hsync_in = hist[i].hs; vsync_in = hist[i].vs;
      hblnk_in = hist[i].hb; vblnk_in = hist[i].vb;
    end
    @(negedge clk);
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    drive_px(0, 0, 12'h000);
    repeat (3) @(negedge clk);
    check("rnd_idle_state", 32'(state), 0);

    run_throw("seq", -1);
    run_throw("ignored", 0);

    // throw coincident with a tick: pending only, start on the next tick
    @(negedge clk) begin throw = 1'b1; vblnk_in = 1'b1; end
    @(negedge clk) begin throw = 1'b0; vblnk_in = 1'b0; end
    @(negedge clk);
    check("coin_state", 32'(state), 0);
    check("coin_busy", 32'(busy), 1);
    do_tick();
    check("coin_start", 32'(state), 32'(2'b01));
    for (int k = 1; k <= 2 * FPS; k++) do_tick();
    check("coin_end_state", 32'(state), 0);
    check("coin_end_busy", 32'(busy), 0);

    // Reset in THROW2
    pulse_throw();
    for (int k = 0; k <= FPS; k++) do_tick();
    check("mid_state", 32'(state), 32'(2'b10));
    @(negedge clk) begin
      rst = 1'b1;
      hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b1;
      drive_px(XP + 10, YP + 10, 12'hFFF);
    end
    @(negedge clk);
    check("mrst_state", 32'(state), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_addr", 32'(pixel_addr), 0);
    check("mrst_timing", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, 0);
    check("mrst_rgb", 32'(rgb_out), 0);
    rst = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0;
    drive_px(0, 0, 12'h000);
    run_throw("fresh", -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
